// File: rtl/mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_sequencer
// Purpose  : Streams operand pairs into a 3-stage MAC and collects each
//            finished signed dot product into a small valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 8,
    parameter int RES_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [LEN_W-1:0]        cfg_count,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    output logic                    mac_load,
    input  logic [2*DATA_WIDTH-1:0] mac_acc,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic                    res_last
);

    localparam int c_AW = $clog2(RES_DEPTH);
    localparam int c_CW = c_AW + 2;
    localparam int c_RW = 2*DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic fin;
    } tag_t;

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, r_count, r_elem, r_vec;
    tag_t               r_s1, r_s2, w_s0;
    logic               r_s3_valid, r_s3_last, r_s3_fin;
    logic               r_done;

    logic [c_RW-1:0]    r_mem [RES_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]      r_fifo_cnt;

    logic               w_beat, w_first, w_last, w_final, w_start_ok;
    logic               w_push, w_pop, w_drain_done;
    logic [c_CW-1:0]    w_pending;
    logic [c_RW-1:0]    w_head;

    // Results already queued plus those still in flight; bounds FIFO occupancy.
    assign w_pending = c_CW'(r_fifo_cnt)
                     + c_CW'(r_s1.valid & r_s1.last)
                     + c_CW'(r_s2.valid & r_s2.last)
                     + c_CW'(r_s3_valid & r_s3_last);

    assign in_ready   = (r_state == S_RUN) && (w_pending < c_CW'(RES_DEPTH));
    assign w_beat     = in_valid && in_ready;
    assign w_first    = (r_elem == '0);
    assign w_last     = (r_elem == r_len - 1'b1);
    assign w_final    = w_last && (r_vec == r_count - 1'b1);
    assign w_start_ok = (r_state == S_IDLE) && start && (cfg_len != '0) && (cfg_count != '0);

    // Idle cycles feed zeros so the accumulator simply holds.
    assign mac_a    = w_beat ? in_a : '0;
    assign mac_b    = w_beat ? in_b : '0;
    assign mac_load = r_s2.valid && r_s2.first;

    assign w_push    = r_s3_valid && r_s3_last;
    assign res_valid = (r_fifo_cnt != '0);
    assign w_pop     = res_valid && res_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign res_data  = res_valid ? w_head[c_RW-1:1] : '0;
    assign res_last  = res_valid && w_head[0];

    assign w_drain_done = w_pop && res_last && (r_fifo_cnt == (c_AW+1)'(1))
                        && !r_s1.valid && !r_s2.valid && !r_s3_valid;

    assign busy = (r_state != S_IDLE);
    assign done = r_done;

    always_comb begin
        w_s0        = '0;
        w_s0.valid  = w_beat;
        w_s0.first  = w_beat && w_first;
        w_s0.last   = w_beat && w_last;
        w_s0.fin    = w_beat && w_final;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)          w_state_nxt = S_RUN;
            S_RUN:   if (w_beat && w_final)   w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done)        w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_DRAIN) && w_drain_done;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len   <= '0;
            r_count <= '0;
            r_elem  <= '0;
            r_vec   <= '0;
        end else if (w_start_ok) begin
            r_len   <= cfg_len;
            r_count <= cfg_count;
            r_elem  <= '0;
            r_vec   <= '0;
        end else if (w_beat) begin
            if (w_last) begin
                r_elem <= '0;
                r_vec  <= r_vec + 1'b1;
            end else begin
                r_elem <= r_elem + 1'b1;
            end
        end
    end

    // Tag stages line up with the MAC operand, product and accumulator registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_fin   <= 1'b0;
        end else begin
            r_s1       <= w_s0;
            r_s2       <= r_s1;
            r_s3_valid <= r_s2.valid;
            r_s3_last  <= r_s2.last;
            r_s3_fin   <= r_s2.fin;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {mac_acc, r_s3_fin};
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_sequencer
// Purpose  : Randomized bench for mac_sequencer with a behavioural MAC and a
//            dot-product reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

    localparam int DW    = 16;
    localparam int LW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [LW-1:0]   cfg_len, cfg_count;
    logic            busy, done;
    logic            in_valid, in_ready;
    logic [DW-1:0]   in_a, in_b;
    logic [DW-1:0]   mac_a, mac_b;
    logic            mac_load;
    logic [2*DW-1:0] mac_acc;
    logic            res_valid, res_ready;
    logic [2*DW-1:0] res_data;
    logic            res_last;

    mac_sequencer #(.DATA_WIDTH(DW), .LEN_W(LW), .RES_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_count(cfg_count),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b), .mac_load(mac_load),
        .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_last(res_last)
    );

    always #5 clk = ~clk;

    // Behavioural 3-stage MAC: operand regs, product reg, accumulator reg.
    logic signed [DW-1:0]   m_a = '0, m_b = '0;
    logic signed [2*DW-1:0] m_mul = '0, m_acc = '0;
    always @(posedge clk) begin
        m_a   <= mac_a;
        m_b   <= mac_b;
        m_mul <= m_a * m_b;
        m_acc <= (mac_load ? '0 : m_acc) + m_mul;
    end
    assign mac_acc = m_acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    logic [32:0]   exp_q[$];
    logic [DW-1:0] op_a[$], op_b[$];
    bit            exp_done     = 1'b0;
    int            t_first_res  = -1;
    int            t_first_valid = 0;
    int            n_beats      = 0;
    int            rdy_pct      = 100;

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            res_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Result scoreboard and done-pulse checker.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (exp_done) begin
                    check("done_pulse", done, 1);
                    check("busy_with_done", busy, 0);
                    exp_done = 1'b0;
                end else if (done) begin
                    check("spurious_done", done, 0);
                end
                if (res_valid && t_first_res < 0) t_first_res = cyc;
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", res_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", res_data, e[31:0]);
                        check("res_last", res_last, e[32]);
                        if (e[32]) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
        int t;
        bit ok;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_a = a; in_b = b;
        t = 0; ok = 1'b0;
        while (!ok && t < 2000) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; t++;
        end
        if (!ok) check("in_ready_timeout", 0, 1);
        else     n_beats++;
        in_valid = 1'b0; in_a = '0; in_b = '0;
    endtask

    task automatic do_start(input int len, input int cnt);
        start = 1'b1; cfg_len = LW'(len); cfg_count = LW'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 5000) begin @(posedge clk); #1; t++; end
        check("batch_finished", busy, 0);
        check("results_drained", exp_q.size(), 0);
    endtask

    task automatic run_batch(input int k, input int n, input int gapmax, input bit poke = 1'b0);
        logic signed [2*DW-1:0] sum;
        logic signed [DW-1:0]   a, b;
        for (int v = 0; v < n; v++) begin
            sum = '0;
            for (int e = 0; e < k; e++) begin
                a = op_a[v*k+e]; b = op_b[v*k+e];
                sum = sum + a * b;
            end
            exp_q.push_back({(v == n-1), sum});
        end
        t_first_res = -1; n_beats = 0;
        do_start(k, n);
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, 1);
        t_first_valid = cyc;
        for (int i = 0; i < k*n; i++) begin
            if (poke && i == 1) begin start = 1'b1; cfg_len = 8'd7; cfg_count = 8'd3; end
            send(op_a[i], op_b[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
            if (poke && i == 1) start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic rand_ops(input int cnt);
        op_a.delete(); op_b.delete();
        for (int i = 0; i < cnt; i++) begin
            op_a.push_back(DW'($urandom)); op_b.push_back(DW'($urandom));
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cfg_len = '0; cfg_count = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);       check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0); check("rst_mac_load", mac_load, 0);
        check("rst_res_valid", res_valid, 0); check("rst_res_last", res_last, 0);
        check("rst_mac_a", mac_a, 0);     check("rst_mac_b", mac_b, 0);
        check("rst_res_data", res_data, 0);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;

        // Basic dot product 70 with latency measurement.
        op_a = '{16'd1, 16'd2, 16'd3, 16'd4}; op_b = '{16'd5, 16'd6, 16'd7, 16'd8};
        run_batch(4, 1, 0);
        check("beat_to_res_valid", t_first_res - t_first_valid, 7);

        // Two vectors with gapped input, -37 each.
        op_a = '{-16'sd2, 16'sd3, -16'sd4, -16'sd2, 16'sd3, -16'sd4};
        op_b = '{16'sd7, -16'sd1, 16'sd5, 16'sd7, -16'sd1, 16'sd5};
        run_batch(3, 2, 3);

        // Back-pressure: FIFO fills, in_ready drops, nothing lost.
        rdy_pct = 0;
        op_a.delete(); op_b.delete();
        for (int i = 0; i < 8; i++) begin op_a.push_back(DW'(i)); op_b.push_back(DW'(i+1)); end
        fork
            run_batch(1, 8, 0);
            begin
                repeat (20) @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                check("stall_beats_taken", n_beats, DEPTH);
                check("stall_res_valid", res_valid, 1);
                rdy_pct = 100;
            end
        join

        // Continuous push/pop streaming, then random back-pressure.
        rdy_pct = 100; rand_ops(24); run_batch(1, 24, 0);
        rdy_pct = 50;  rand_ops(24); run_batch(2, 12, 2);

        // Wraparound.
        rdy_pct = 100;
        op_a = '{16'h8000, 16'h8000}; op_b = '{16'h8000, 16'h8000};
        run_batch(2, 1, 0);

        // Ignored starts.
        do_start(0, 3);
        check("len0_busy", busy, 0); check("len0_in_ready", in_ready, 0);
        do_start(4, 0);
        check("cnt0_busy", busy, 0); check("cnt0_in_ready", in_ready, 0);
        repeat (3) begin @(posedge clk); #1; end

        // Start pulse while busy must not disturb the batch.
        rand_ops(3); run_batch(3, 1, 1, 1'b1);

        // Reset mid-vector.
        do_start(5, 2);
        send(16'd3, 16'd4, 0); send(16'd5, 16'd6, 0);
        in_valid = 1'b1; in_a = 16'd123; in_b = 16'd45;
        reset = 1'b0; #1;
        check("mid_rst_busy", busy, 0);       check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_mac_load", mac_load, 0); check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_mac_a", mac_a, 0);     check("mid_rst_done", done, 0);
        in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        rand_ops(12); run_batch(4, 3, 1);

        // Randomized batches.
        for (int r = 0; r < 4; r++) begin
            int k, n;
            k = $urandom_range(1, 6); n = $urandom_range(1, 5);
            rdy_pct = $urandom_range(30, 100);
            rand_ops(k*n);
            run_batch(k, n, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_sequencer.md
# mac_sequencer

Control block that sequences one pipelined multiply-accumulate unit (3-stage: operand regs, product reg, accumulator reg; `load` zeroes the accumulator feedback) to compute a programmed batch of signed dot products. Accepts an operand-pair stream, drives the MAC operands and `load` at the correct pipeline offsets, inserts zero bubbles on stalls, and captures each finished dot product into a small result FIFO with valid/ready output. Sits between the matrix-multiply operand fetch logic and the result writeback path.

## Interface
- `DATA_WIDTH`, 16, operand width; results are `2*DATA_WIDTH`.
- `LEN_W`, 8, width of vector-length and vector-count fields.
- `RES_DEPTH`, 4, result FIFO entries (power of two, ≥2).
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `cfg_len` in LEN_W: elements per dot product K, captured on start.
- `cfg_count` in LEN_W: number of dot products N, captured on start.
- `busy` out 1: high from accepted start until done.
- `done` out 1: one-cycle pulse after the final result handshake.
- `in_valid` / `in_ready` in/out 1: operand-pair handshake.
- `in_a`, `in_b` in DATA_WIDTH: signed operands.
- `mac_a`, `mac_b` out DATA_WIDTH: to MAC `a`/`b`.
- `mac_load` out 1: to MAC `load`.
- `mac_acc` in 2*DATA_WIDTH: from MAC `acc`.
- `res_valid` / `res_ready` out/in 1: result handshake.
- `res_data` out 2*DATA_WIDTH: dot product, signed, wraps modulo 2^(2*DATA_WIDTH).
- `res_last` out 1: high with the N-th result of the batch.

## Operation
- States: IDLE, RUN, DRAIN. IDLE→RUN on `start` with cfg_len≠0 and cfg_count≠0; start with either zero, or start outside IDLE, is ignored (no busy, no done).
- RUN: beat fires when `in_valid && in_ready`. Element counter 0..K-1 tags each beat first (elem==0) and last (elem==K-1); counter wraps to 0 on last; vector counter increments on last. After the N-th vector's last beat fires → DRAIN.
- `mac_a`/`mac_b` = `in_a`/`in_b` on a firing beat, else 0 (zero product, accumulator holds value).
- Tag pipeline s1,s2,s3 of {valid, first, last, final}, advancing every cycle, aligned with MAC a_reg, mul_reg, acc_reg.
- `mac_load` = s2.valid && s2.first (combinational from s2 register).
- Capture: when s3.valid && s3.last, push {`mac_acc`, s3.final} into the FIFO.
- `in_ready` = (state==RUN) && (fifo_count + number of last tags in s1..s3 < RES_DEPTH); independent of `in_valid`. Guarantees no FIFO overflow.
- DRAIN → IDLE when tag pipeline empty, FIFO empty, and the final result handshakes; `done` pulses the following cycle, `busy` drops with it.
- FIFO: `res_valid` = not empty; pop on `res_valid && res_ready`; simultaneous push and pop allowed at any occupancy, including full.
- K=1: first and last coincide; load and capture both occur for that beat.

## Timing
- Reset values: `busy`, `done`, `in_ready`, `mac_load`, `res_valid`, `res_last` = 0; `mac_a`, `mac_b`, `res_data` = 0; FIFO empty, tags invalid, counters 0, state IDLE.
- Start in cycle t → `busy` and `in_ready` high in t+1.
- Last beat fires in cycle c → `mac_load` for a first beat at c is high in c+2; result in `mac_acc` in c+3; `res_valid` high in c+4 (4-cycle last-beat-to-result latency).
- Back-to-back vectors with no gaps are supported; next vector's load lands in the same cycle the previous result is captured.
- Input stalls insert zero bubbles and never corrupt the accumulation.
- Reset mid-batch: all state cleared immediately; MAC accumulator contents are don't-care since the next first beat asserts load.

## Test plan
- K=4, N=1, a={1,2,3,4}, b={5,6,7,8} streamed back-to-back from cycle c → res_data=70, res_last=1, res_valid at c+7; done one cycle after handshake.
- K=3, N=2 with in_valid gapped randomly, a=-2,3,-4 and b=7,-1,5 for both vectors → two results of -37, res_last only on the second.
- K=1, N=8, a=i, b=i+1, res_ready held low → in_ready drops once 4 results are pending; release res_ready → results 0,2,6,...,56 in order, none lost.
- Full FIFO with simultaneous push and pop every cycle → occupancy stays constant, data order preserved.
- Wraparound: DATA_WIDTH=16, K=2, a=b=-32768 → res_data = 0x80000000.
- start with cfg_len=0, start while busy, and reset asserted mid-vector → ignored, ignored, all outputs at reset values; a fresh batch afterward yields correct results.
